multiplier_step_counter: RTL

// Parametrised iteration sequencer for the shift-add multiplier control path.

---
 rtl/multiplier_step_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/multiplier_step_counter.sv
// Iteration sequencer for the shift-add multiplier: one do_step per radix-2^R step,
// with step index, last-step flag, stall hold, abort and a single-cycle done pulse.
module multiplier_step_counter #(
   parameter int N = 8,
   parameter int R = 1,
   localparam int S = (N + R - 1) / R,
   localparam int C = (S > 1) ? $clog2(S) : 1,
   localparam int L = $clog2(N + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [L-1:0] length,
   input  logic         stall,
   input  logic         abort,
   output logic         ready,
   output logic         busy,
   output logic         do_step,
   output logic [C-1:0] step_index,
   output logic         last_step,
   output logic         done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   state;
   logic [C-1:0] remaining;
   logic [L:0]   len_clamped;
   logic [L:0]   steps;

   // One extra bit keeps the round-up addition from overflowing for any length.
   always_comb begin
      len_clamped = {1'b0, length};
      if (length > L'(N)) begin
         len_clamped = (L + 1)'(N);
      end
      steps = (len_clamped + (L + 1)'(R - 1)) / (L + 1)'(R);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         remaining  <= '0;
         step_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (steps == '0) begin
                     state <= DONE;
                  end else begin
                     state      <= RUN;
                     remaining  <= C'(steps - (L + 1)'(1));
                     step_index <= '0;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state      <= IDLE;
                  remaining  <= '0;
                  step_index <= '0;
               end else if (!stall) begin
                  if (remaining == '0) begin
                     state <= DONE;
                  end else begin
                     remaining  <= remaining - C'(1);
                     step_index <= step_index + C'(1);
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               remaining  <= '0;
               step_index <= '0;
            end
            default: begin
               state      <= IDLE;
               remaining  <= '0;
               step_index <= '0;
            end
         endcase
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == RUN);
   assign do_step   = busy && !stall;
   assign last_step = busy && (remaining == '0);
   assign done      = (state == DONE);

endmodule
